vec_cache_wr_data_master_arbiter: RTL

//  N-to-M upstream crossbar: collects write-data beats from N masters and steers each beat to
//  one of M cache-side ports chosen by its per-beat destination index. Arbitrates per output

---
 rtl/vec_cache_wr_data_master_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/vec_cache_wr_data_master_arbiter.sv
// Purpose : N-to-M write-data crossbar; per-output round-robin arbitration into a 1-entry output register,
//           stamping the source master index into txnid.master_id.
// Latency : 1 cycle from accepted beat to out_vld/out_pld; no bubbles while downstream stays ready.
// Backpressure: an output that holds a beat while !out_rdy grants nobody, so in_rdy stays low for every
//           master aimed at it; other outputs keep flowing.
// Ports   : clk, rst_n (sync, active-low) | in_vld/in_rdy/in_pld/in_dst per master (N) |
//           out_vld/out_rdy/out_pld per cache-side port (M)

package vec_cache_wr_pkg;
  localparam int MID_W = 4;

  typedef struct packed {
    logic [MID_W-1:0] master_id;
    logic [7:0]       tag;
  } txnid_t;

  typedef struct packed {
    txnid_t      txnid;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } us_data_pld_t;
endpackage

module vec_cache_wr_data_master_arbiter
  import vec_cache_wr_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 16,
  localparam int DST_W = (M > 1) ? $clog2(M) : 1,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_vld,
  output logic [N-1:0]       in_rdy,
  input  us_data_pld_t       in_pld [N],
  input  logic [DST_W-1:0]   in_dst [N],
  output logic [M-1:0]       out_vld,
  input  logic [M-1:0]       out_rdy,
  output us_data_pld_t       out_pld [M]
);

  logic [M-1:0]     load;
  logic [M-1:0]     gnt_vld;
  logic [IDX_W-1:0] gnt_idx [M];
  logic [IDX_W-1:0] rr_ptr  [M];
  us_data_pld_t     ld_pld  [M];

  // Per-output circular search starting at rr_ptr; the first requester found wins.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_b;
    idx    = 0;
    idx_b  = '0;
    in_rdy = '0;
    for (int j = 0; j < M; j++) begin
      load[j]    = !out_vld[j] || out_rdy[j];
      gnt_vld[j] = 1'b0;
      gnt_idx[j] = '0;
      for (int k = 0; k < N; k++) begin
        idx = int'(rr_ptr[j]) + k;
        if (idx >= N) idx = idx - N;
        idx_b = IDX_W'(idx);
        if (load[j] && !gnt_vld[j] && in_vld[idx_b] && (int'(in_dst[idx_b]) == j)) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = idx_b;
        end
      end
      ld_pld[j]                 = in_pld[gnt_idx[j]];
      ld_pld[j].txnid.master_id = MID_W'(gnt_idx[j]);
      // A master only ever matches the port in its own in_dst, so at most one
      // output can set its ready bit.
      if (gnt_vld[j] && rst_n) in_rdy[gnt_idx[j]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld <= '0;
      for (int j = 0; j < M; j++) begin
        out_pld[j] <= '0;
        rr_ptr[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < M; j++) begin
        if (gnt_vld[j]) begin
          out_vld[j] <= 1'b1;
          out_pld[j] <= ld_pld[j];
          rr_ptr[j]  <= (gnt_idx[j] == IDX_W'(N - 1)) ? '0 : gnt_idx[j] + 1'b1;
        end else if (out_rdy[j]) begin
          // Drained with nothing to replace it; payload keeps its last value.
          out_vld[j] <= 1'b0;
        end
      end
    end
  end

  // Destinations beyond M-1 can only exist when M is not a power of two;
  // such a master is silently never granted, so flag it in simulation.
  generate
    if (M < (1 << DST_W)) begin : g_dst_chk
      for (genvar i = 0; i < N; i++) begin : g_mst
        a_dst_range : assert property (@(posedge clk) disable iff (!rst_n)
          !(in_vld[i] && (int'(in_dst[i]) >= M)));
      end
    end
  endgenerate

endmodule
